// File: rtl/node_invoker.sv
// -----------------------------------------------------------------------------
// node_invoker
//
// Initiator side of the node start/ready protocol. Operand requests are
// buffered in a small FIFO; one child-node computation is launched at a time
// by driving the operands and a start level, the child's ready line is
// tracked, and the captured result is returned with a valid/ready handshake.
//
// Optional feature (compile-time macro NODE_TIMEOUT_EN):
//   When defined, a watchdog counts cycles spent in START/WAIT. Reaching
//   TIMEOUT_CYC abandons the child and returns an error response
//   (rsp_res_o = 0, rsp_err_o = 1). When undefined the invoker waits
//   indefinitely and rsp_err_o never asserts.
//
// Parameters:
//   WIDTH        operand/result width
//   DEPTH        request FIFO entries (power of two, >= 2)
//   TIMEOUT_CYC  watchdog limit in cycles (NODE_TIMEOUT_EN builds only)
//
// Ports:
//   clk_i      clock, all logic on the rising edge
//   rst_ni     asynchronous active-low reset
//   req_v_i    request valid
//   req_rdy_o  FIFO not full; a request is pushed on req_v_i & req_rdy_o
//   req_a0_i   operand for child IN0
//   req_a1_i   operand for child IN1
//   n_st_o     start level to child ST
//   n_in0_o    child IN0, held stable for the whole computation
//   n_in1_o    child IN1, held stable for the whole computation
//   n_rd_i     child RD (1 = idle/done, 0 = computing)
//   n_res_i    child RES, valid while n_rd_i = 1 after a computation
//   rsp_v_o    response valid
//   rsp_rdy_i  response accepted on rsp_v_o & rsp_rdy_i
//   rsp_res_o  captured result
//   rsp_err_o  watchdog expiry flag
//   busy_o     FSM not idle
//   count_o    FIFO occupancy
// -----------------------------------------------------------------------------
module node_invoker #(
    parameter int WIDTH       = 16,
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_v_i,
    output logic                   req_rdy_o,
    input  logic [WIDTH-1:0]       req_a0_i,
    input  logic [WIDTH-1:0]       req_a1_i,
    output logic                   n_st_o,
    output logic [WIDTH-1:0]       n_in0_o,
    output logic [WIDTH-1:0]       n_in1_o,
    input  logic                   n_rd_i,
    input  logic [WIDTH-1:0]       n_res_i,
    output logic                   rsp_v_o,
    input  logic                   rsp_rdy_i,
    output logic [WIDTH-1:0]       rsp_res_o,
    output logic                   rsp_err_o,
    output logic                   busy_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] mem_a0_q [DEPTH];
    logic [WIDTH-1:0] mem_a1_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    assign fifo_full  = (count_q == CW'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push       = req_v_i && !fifo_full;

    // Storage carries no reset: occupancy and pointers alone define which
    // entries are meaningful.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_a0_q[wr_ptr_q] <= req_a0_i;
            mem_a1_q[wr_ptr_q] <= req_a1_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        // Simultaneous push and pop leaves the occupancy unchanged.
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    state_t state_q, state_d;
    logic   tmo_expire;

`ifdef NODE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] tmr_q, tmr_d;
    logic          tmr_run;

    // The counter sits at zero outside START/WAIT, so it is already clear
    // when a launch enters START.
    assign tmr_run    = (state_q == S_START) || (state_q == S_WAIT);
    assign tmr_d      = tmr_run ? (tmr_q + TW'(1)) : '0;
    // Expiry fires on the edge that completes the TIMEOUT_CYC-th cycle
    // spent in START/WAIT.
    assign tmo_expire = tmr_run && (tmr_q == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end
`else
    // Never fires; the comparison keeps the parameter referenced.
    assign tmo_expire = (TIMEOUT_CYC < 0);
`endif

    // ------------------------------------------------------------------
    // Launch / response FSM (all outputs registered)
    // ------------------------------------------------------------------
    logic             n_st_q,    n_st_d;
    logic [WIDTH-1:0] n_in0_q,   n_in0_d;
    logic [WIDTH-1:0] n_in1_q,   n_in1_d;
    logic             rsp_v_q,   rsp_v_d;
    logic [WIDTH-1:0] rsp_res_q, rsp_res_d;
    logic             rsp_err_q, rsp_err_d;

    always_comb begin
        state_d   = state_q;
        n_st_d    = n_st_q;
        n_in0_d   = n_in0_q;
        n_in1_d   = n_in1_q;
        rsp_v_d   = rsp_v_q;
        rsp_res_d = rsp_res_q;
        rsp_err_d = rsp_err_q;
        pop       = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A low ready line means the child is still settling from a
                // previous (possibly abandoned) run, so hold off the launch.
                if (!fifo_empty && n_rd_i) begin
                    pop     = 1'b1;
                    n_in0_d = mem_a0_q[rd_ptr_q];
                    n_in1_d = mem_a1_q[rd_ptr_q];
                    n_st_d  = 1'b1;
                    state_d = S_START;
                end
            end

            S_START: begin
                if (!n_rd_i) begin
                    // Child acknowledged the start.
                    n_st_d  = 1'b0;
                    state_d = S_WAIT;
                end else if (tmo_expire) begin
                    n_st_d    = 1'b0;
                    rsp_res_d = '0;
                    rsp_err_d = 1'b1;
                    rsp_v_d   = 1'b1;
                    state_d   = S_HOLD;
                end
            end

            S_WAIT: begin
                // Level detection is safe: WAIT is only reached after the
                // ready line was seen low for this computation.
                if (n_rd_i) begin
                    rsp_res_d = n_res_i;
                    rsp_err_d = 1'b0;
                    rsp_v_d   = 1'b1;
                    state_d   = S_HOLD;
                end else if (tmo_expire) begin
                    rsp_res_d = '0;
                    rsp_err_d = 1'b1;
                    rsp_v_d   = 1'b1;
                    state_d   = S_HOLD;
                end
            end

            S_HOLD: begin
                if (rsp_rdy_i) begin
                    rsp_v_d = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            n_st_q    <= 1'b0;
            n_in0_q   <= '0;
            n_in1_q   <= '0;
            rsp_v_q   <= 1'b0;
            rsp_res_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            n_st_q    <= n_st_d;
            n_in0_q   <= n_in0_d;
            n_in1_q   <= n_in1_d;
            rsp_v_q   <= rsp_v_d;
            rsp_res_q <= rsp_res_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_rdy_o = !fifo_full;
    assign count_o   = count_q;
    assign busy_o    = (state_q != S_IDLE);
    assign n_st_o    = n_st_q;
    assign n_in0_o   = n_in0_q;
    assign n_in1_o   = n_in1_q;
    assign rsp_v_o   = rsp_v_q;
    assign rsp_res_o = rsp_res_q;
    assign rsp_err_o = rsp_err_q;

endmodule

// File: tb/tb_node_invoker.sv
// -----------------------------------------------------------------------------
// tb_node_invoker
//
// Bench for node_invoker: a behavioural child node, a transaction-level model
// of the invoker (request queue, one computation in flight, in-order results)
// checked every cycle, and directed scenarios with hand-computed literals.
// -----------------------------------------------------------------------------
module tb_node_invoker;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
`ifdef NODE_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1024;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_v = 1'b0;
    logic [WIDTH-1:0]  req_a0 = '0;
    logic [WIDTH-1:0]  req_a1 = '0;
    logic              n_rd = 1'b1;
    logic [WIDTH-1:0]  n_res = '0;
    logic              rsp_rdy = 1'b0;

    logic              req_rdy_o;
    logic              n_st_o;
    logic [WIDTH-1:0]  n_in0_o;
    logic [WIDTH-1:0]  n_in1_o;
    logic              rsp_v_o;
    logic [WIDTH-1:0]  rsp_res_o;
    logic              rsp_err_o;
    logic              busy_o;
    logic [2:0]        count_o;

    node_invoker #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .req_v_i   (req_v),
        .req_rdy_o (req_rdy_o),
        .req_a0_i  (req_a0),
        .req_a1_i  (req_a1),
        .n_st_o    (n_st_o),
        .n_in0_o   (n_in0_o),
        .n_in1_o   (n_in1_o),
        .n_rd_i    (n_rd),
        .n_res_i   (n_res),
        .rsp_v_o   (rsp_v_o),
        .rsp_rdy_i (rsp_rdy),
        .rsp_res_o (rsp_res_o),
        .rsp_err_o (rsp_err_o),
        .busy_o    (busy_o),
        .count_o   (count_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Child computation: RES = 12*IN0 + 6*IN1 (3,5 -> 0x0042).
    function automatic logic [WIDTH-1:0] child_f(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return a * 16'd12 + b * 16'd6;
    endfunction

    // ------------------------------------------------------------------
    // Behavioural child: drops RD 2 cycles after seeing ST, raises RD with
    // the result 10 cycles after. blk_rd forces RD low (child quiescing);
    // tmo_mode makes the child ignore ST entirely.
    // ------------------------------------------------------------------
    bit               blk_rd = 1'b0;
    bit               tmo_mode = 1'b0;
    bit               c_busy = 1'b0;
    int               c_cnt = 0;
    logic [WIDTH-1:0] c_a = '0;
    logic [WIDTH-1:0] c_b = '0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (c_busy) begin
                c_cnt++;
                if (c_cnt == 2) n_rd = 1'b0;
                if (c_cnt == 10) begin
                    n_rd   = 1'b1;
                    n_res  = child_f(c_a, c_b);
                    c_busy = 1'b0;
                end
            end else if (blk_rd) begin
                n_rd = 1'b0;
            end else begin
                n_rd = 1'b1;
                if (n_st_o && !tmo_mode) begin
                    c_busy = 1'b1;
                    c_cnt  = 0;
                    c_a    = n_in0_o;
                    c_b    = n_in1_o;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Transaction model: queue of pending requests, at most one in flight,
    // launched only when idle with a non-empty queue and RD high, retired
    // when its response is accepted.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [WIDTH-1:0] a0;
        logic [WIDTH-1:0] a1;
    } req_t;

    req_t             m_q[$];
    req_t             m_cur = '0;
    bit               m_busy = 1'b0;
    bit               m_tmo = 1'b0;
    bit               p_push = 1'b0;
    bit               p_launch = 1'b0;
    bit               p_acc = 1'b0;
    req_t             p_req = '0;
    logic [WIDTH-1:0] acc_log[$];

    // Apply the events decided from the stable pre-edge values.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_busy   = 1'b0;
            p_push   = 1'b0;
            p_launch = 1'b0;
            p_acc    = 1'b0;
        end else begin
            if (p_acc) m_busy = 1'b0;
            if (p_launch) begin
                m_cur  = m_q.pop_front();
                m_busy = 1'b1;
                m_tmo  = tmo_mode;
            end
            if (p_push) m_q.push_back(p_req);
            p_push   = 1'b0;
            p_launch = 1'b0;
            p_acc    = 1'b0;
        end
    end

    // Compare process: checks outputs against the model mid-cycle and
    // decides what the next edge will do.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("count", count_o, m_q.size());
            chk("req_rdy", req_rdy_o, m_q.size() < DEPTH);
            chk("busy", busy_o, m_busy);
            if (m_busy) begin
                chk("n_in0", n_in0_o, m_cur.a0);
                chk("n_in1", n_in1_o, m_cur.a1);
            end else begin
                chk("rsp_v_idle", rsp_v_o, 1'b0);
            end
`ifndef NODE_TIMEOUT_EN
            chk("rsp_err_zero", rsp_err_o, 1'b0);
`endif
            if (rsp_v_o && rsp_rdy) begin
                chk("rsp_res", rsp_res_o, m_tmo ? 16'h0000 : child_f(m_cur.a0, m_cur.a1));
                chk("rsp_err", rsp_err_o, m_tmo);
                acc_log.push_back(rsp_res_o);
                $display("RSP res=0x%04h err=%0d at %0t", rsp_res_o, rsp_err_o, $time);
            end
            p_push   = req_v && (m_q.size() < DEPTH);
            p_req    = {req_a0, req_a1};
            p_launch = !m_busy && (m_q.size() != 0) && n_rd;
            p_acc    = m_busy && rsp_v_o && rsp_rdy;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after the rising edge)
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] a1);
        int k;
        k      = 0;
        req_v  = 1'b1;
        req_a0 = a0;
        req_a1 = a1;
        while (!req_rdy_o && k < 300) begin
            step();
            k++;
        end
        if (!req_rdy_o) chk("push_wait", req_rdy_o, 1'b1);
        step();
        req_v = 1'b0;
        $display("REQ a0=0x%04h a1=0x%04h at %0t", a0, a1, $time);
    endtask

    function automatic logic pick(input int sel);
        case (sel)
            0:       return n_st_o;
            1:       return rsp_v_o;
            default: return busy_o;
        endcase
    endfunction

    task automatic wait_for(input int sel, input logic val, input int lim, input string name, output int cyc);
        cyc = 0;
        while (pick(sel) !== val && cyc < lim) begin
            step();
            cyc++;
        end
        if (pick(sel) !== val) chk(name, pick(sel), val);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k       = 0;
        rsp_rdy = 1'b1;
        while ((busy_o || count_o != 0) && k < 2000) begin
            step();
            k++;
        end
        if (busy_o || count_o != 0) chk(name, {count_o, busy_o}, 4'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_count"},   count_o,   3'd0);
        chk({tag, "_req_rdy"}, req_rdy_o, 1'b1);
        chk({tag, "_n_st"},    n_st_o,    1'b0);
        chk({tag, "_n_in0"},   n_in0_o,   16'h0000);
        chk({tag, "_n_in1"},   n_in1_o,   16'h0000);
        chk({tag, "_rsp_v"},   rsp_v_o,   1'b0);
        chk({tag, "_rsp_res"}, rsp_res_o, 16'h0000);
        chk({tag, "_rsp_err"}, rsp_err_o, 1'b0);
        chk({tag, "_busy"},    busy_o,    1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // ------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------
    initial begin
        int cyc;
        int lat;
        int st_cyc;
        int rises;
        logic prev;

        rst_n = 1'b0;
        repeat (3) step();
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        step();

        // 1: single request 3,5 -> 0x0042 after 11 cycles, one 3-cycle ST pulse
        rsp_rdy = 1'b0;
        push_req(16'd3, 16'd5);
        wait_for(0, 1'b1, 20, "t1_launch", cyc);
        chk("t1_in0", n_in0_o, 16'd3);
        chk("t1_in1", n_in1_o, 16'd5);
        lat    = 0;
        st_cyc = 0;
        rises  = 0;
        prev   = 1'b1;
        while (!rsp_v_o && lat < 100) begin
            if (n_st_o) st_cyc++;
            if (n_st_o && !prev) rises++;
            prev = n_st_o;
            step();
            lat++;
        end
        chk("t1_latency", lat, 11);
        chk("t1_st_cycles", st_cyc, 3);
        chk("t1_extra_st", rises, 0);
        chk("t1_res", rsp_res_o, 16'h0042);
        chk("t1_err", rsp_err_o, 1'b0);
        chk("t1_in0_held", n_in0_o, 16'd3);
        rsp_rdy = 1'b1;
        step();
        rsp_rdy = 1'b0;
        chk("t1_rsp_v_after", rsp_v_o, 1'b0);

        // 2: five requests with launch blocked; FIFO fills at 4
        acc_log.delete();
        blk_rd  = 1'b1;
        rsp_rdy = 1'b1;
        step();
        step();
        fork
            begin
                push_req(16'd1, 16'd1);
                push_req(16'd2, 16'd1);
                push_req(16'd4, 16'd2);
                push_req(16'd10, 16'd0);
                push_req(16'd0, 16'd10);
            end
        join_none
        repeat (12) step();
        chk("t2_count_full", count_o, 3'd4);
        chk("t2_rdy_full", req_rdy_o, 1'b0);
        chk("t2_no_launch", busy_o, 1'b0);
        blk_rd = 1'b0;
        wait fork;
        wait_idle("t2_drain");
        chk("t2_n", acc_log.size(), 5);
        if (acc_log.size() == 5) begin
            chk("t2_r0", acc_log[0], 16'h0012);
            chk("t2_r1", acc_log[1], 16'h001E);
            chk("t2_r2", acc_log[2], 16'h003C);
            chk("t2_r3", acc_log[3], 16'h0078);
            chk("t2_r4", acc_log[4], 16'h003C);
        end

        // 3: response held 20 cycles; FIFO keeps filling, no new launch
        acc_log.delete();
        rsp_rdy = 1'b0;
        push_req(16'd5, 16'd5);
        wait_for(1, 1'b1, 100, "t3_rsp", cyc);
        fork
            begin
                push_req(16'd1, 16'd0);
                push_req(16'd2, 16'd0);
                push_req(16'd3, 16'd0);
                push_req(16'd4, 16'd0);
            end
        join_none
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t3_rsp_v", rsp_v_o, 1'b1);
            chk("t3_res", rsp_res_o, 16'h005A);
            chk("t3_st", n_st_o, 1'b0);
        end
        chk("t3_count", count_o, 3'd4);
        chk("t3_rdy", req_rdy_o, 1'b0);
        wait fork;
        wait_idle("t3_drain");
        chk("t3_n", acc_log.size(), 5);
        if (acc_log.size() == 5) begin
            chk("t3_r0", acc_log[0], 16'h005A);
            chk("t3_r4", acc_log[4], 16'h0030);
        end

        // 4: reset while waiting on the child
        acc_log.delete();
        rsp_rdy = 1'b1;
        push_req(16'd7, 16'd7);
        wait_for(0, 1'b1, 20, "t4_launch", cyc);
        wait_for(0, 1'b0, 20, "t4_wait", cyc);
        step();
        step();
        chk("t4_busy_before", busy_o, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("t4");
        step();
        step();
        rst_n = 1'b1;
        push_req(16'd6, 16'd1);
        wait_idle("t4_drain");
        chk("t4_n", acc_log.size(), 1);
        if (acc_log.size() == 1) chk("t4_r0", acc_log[0], 16'h004E);

`ifdef NODE_TIMEOUT_EN
        // 5: child never acknowledges -> error response after 16 cycles
        acc_log.delete();
        rsp_rdy  = 1'b0;
        tmo_mode = 1'b1;
        push_req(16'd1, 16'd2);
        wait_for(0, 1'b1, 20, "t5_launch", cyc);
        lat = 0;
        while (!rsp_v_o && lat < 100) begin
            step();
            lat++;
        end
        chk("t5_latency", lat, 16);
        chk("t5_err", rsp_err_o, 1'b1);
        chk("t5_res", rsp_res_o, 16'h0000);
        chk("t5_st", n_st_o, 1'b0);
        rsp_rdy = 1'b1;
        step();
        tmo_mode = 1'b0;
        push_req(16'd2, 16'd2);
        wait_idle("t5_drain");
        chk("t5_n", acc_log.size(), 2);
        if (acc_log.size() == 2) chk("t5_r1", acc_log[1], 16'h0024);
`endif

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
